// File: rtl/tt_um_mattvenn_rgb_mixer_core.sv
// RGB mixer core: three quadrature encoders, each debounced and decoded into
// an 8-bit level that drives one PWM output from a shared free-running counter.
// uio_out exposes one selected level for debugging.
module tt_um_mattvenn_rgb_mixer_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       srst;
    logic [5:0] deb;
    logic [7:0] value [3];
    logic [2:0] pwm;
    logic [7:0] counter_reg;
    logic       unused;

    assign srst   = ~rst_n;
    assign unused = &{ena, uio_in, 1'b0};

    // One debouncer per encoder pin: the output only flips once eight
    // consecutive samples agree, so any shorter pulse is swallowed.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_debounce
            logic [7:0] hist_reg;
            logic [7:0] hist_next;
            logic       deb_reg;

            assign hist_next = {hist_reg[6:0], ui_in[gi]};

            // Shift in the raw pin; flip the output on the edge the history saturates
            always_ff @(posedge clk) begin
                if (srst) begin
                    hist_reg <= 8'h00;
                    deb_reg  <= 1'b0;
                end else begin
                    hist_reg <= hist_next;
                    if (hist_next == 8'hFF) begin
                        deb_reg <= 1'b1;
                    end else if (hist_next == 8'h00) begin
                        deb_reg <= 1'b0;
                    end
                end
            end

            assign deb[gi] = deb_reg;
        end
    endgenerate

    // Shared PWM timebase, wraps naturally at 256
    always_ff @(posedge clk) begin
        if (srst) begin
            counter_reg <= 8'h00;
        end else begin
            counter_reg <= counter_reg + 8'd1;
        end
    end

    // Per-channel quadrature decode, level register and PWM comparator.
    // Only A edges count; B just selects the direction, so bouncing B
    // transitions can never move the level.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_channel
            logic       a;
            logic       b;
            logic       a_dly_reg;
            logic [7:0] value_reg;
            logic       pwm_reg;
            logic       step_up;
            logic       step_down;

            assign a = deb[2*gi];
            assign b = deb[2*gi+1];

            // A rising with B low or A falling with B high counts up; the opposite pairs count down
            always_comb begin
                step_up   = 1'b0;
                step_down = 1'b0;
                if (a != a_dly_reg) begin
                    step_up   = (a != b);
                    step_down = (a == b);
                end
            end

            // Level register with modulo-256 wrap, plus the delayed A used for edge detection
            always_ff @(posedge clk) begin
                if (srst) begin
                    a_dly_reg <= 1'b0;
                    value_reg <= 8'h00;
                end else begin
                    a_dly_reg <= a;
                    if (step_up) begin
                        value_reg <= value_reg + 8'd1;
                    end else if (step_down) begin
                        value_reg <= value_reg - 8'd1;
                    end
                end
            end

            // Registered comparator: high for value_reg out of every 256 cycles
            always_ff @(posedge clk) begin
                if (srst) begin
                    pwm_reg <= 1'b0;
                end else begin
                    pwm_reg <= (counter_reg < value_reg);
                end
            end

            assign value[gi] = value_reg;
            assign pwm[gi]   = pwm_reg;
        end
    endgenerate

    // Debug readback of one channel level, selected by ui_in[7:6]
    always_comb begin
        uio_out = 8'h00;
        case (ui_in[7:6])
            2'd0:    uio_out = value[0];
            2'd1:    uio_out = value[1];
            2'd2:    uio_out = value[2];
            default: uio_out = 8'h00;
        endcase
    end

    assign uo_out = {5'b00000, pwm};
    assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_tt_um_mattvenn_rgb_mixer_core.sv
// Self-checking bench for the RGB mixer core. A behavioural model tracks the
// encoder pin levels and the expected channel levels using the quadrature
// rule directly (an A change counts up when the new A differs from B).
module tb_tt_um_mattvenn_rgb_mixer_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         tests = 0;
    int         fails = 0;
    bit   [2:0] pa = 3'b000;
    bit   [2:0] pb = 3'b000;
    bit   [1:0] dbg = 2'd0;
    logic [7:0] ev [3];

    tt_um_mattvenn_rgb_mixer_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic drive();
        ui_in = {dbg, pb[2], pa[2], pb[1], pa[1], pb[0], pa[0]};
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Read every debug selection and compare against the model
    task automatic check_vals(input string tag);
        for (int m = 0; m < 4; m++) begin
            dbg = 2'(m);
            drive();
            #1;
            chk($sformatf("%s_dbg%0d", tag, m), int'(uio_out), (m == 3) ? 0 : int'(ev[m]));
        end
        chk({tag, "_uo_hi"}, int'(uo_out[7:3]), 0);
        chk({tag, "_oe"}, int'(uio_oe), 8'hFF);
        dbg = 2'd0;
        drive();
    endtask

    // One quadrature step on a channel; A changes are checked for latency
    task automatic move(input int ch, input bit fwd);
        logic [7:0] old_v;
        bit         change_a;
        old_v    = ev[ch];
        change_a = fwd ? (pa[ch] == pb[ch]) : (pa[ch] != pb[ch]);
        if (change_a) begin
            pa[ch] = ~pa[ch];
            ev[ch] = (pa[ch] != pb[ch]) ? ev[ch] + 8'd1 : ev[ch] - 8'd1;
        end else begin
            pb[ch] = ~pb[ch];
        end
        dbg = 2'(ch);
        drive();
        tick(7);
        chk($sformatf("early_ch%0d", ch), int'(uio_out), int'(old_v));
        tick(3);
        chk($sformatf("settle_ch%0d", ch), int'(uio_out), int'(ev[ch]));
        tick(2);
    endtask

    task automatic set_val(input int ch, input logic [7:0] target);
        logic [7:0] diff;
        while (ev[ch] != target) begin
            diff = target - ev[ch];
            move(ch, diff < 8'd128);
        end
    endtask

    // Short pulse on one pin must leave the level untouched
    task automatic glitch(input int ch, input bit on_a);
        int len;
        len = $urandom_range(1, 7);
        if (on_a) pa[ch] = ~pa[ch]; else pb[ch] = ~pb[ch];
        dbg = 2'(ch);
        drive();
        tick(len);
        if (on_a) pa[ch] = ~pa[ch]; else pb[ch] = ~pb[ch];
        drive();
        tick(10);
        chk($sformatf("glitch%0d_ch%0d", len, ch), int'(uio_out), int'(ev[ch]));
    endtask

    task automatic pwm_chk(input int ch);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (uo_out[ch]) cnt++;
            tick(1);
        end
        chk($sformatf("pwm%0d_duty", ch), cnt, int'(ev[ch]));
    endtask

    initial begin
        ev[0] = 8'd0; ev[1] = 8'd0; ev[2] = 8'd0;
        ena    = 1'b1;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        drive();

        // Reset state under every debug selection
        tick(5);
        chk("rst_uo", int'(uo_out), 0);
        check_vals("rst");
        rst_n = 1'b1;
        tick(3);
        check_vals("post_rst");

        // 20 full forward quadrature cycles on channel 0
        for (int i = 0; i < 80; i++) move(0, 1'b1);
        check_vals("fwd20");

        // One reverse step on channel 1 wraps 0 -> 255
        move(1, 1'b0);
        move(1, 1'b0);
        check_vals("rev1");

        // Short glitches on channel 2 (and others) are rejected
        for (int i = 0; i < 6; i++) glitch(2, 1'b1);
        glitch(0, 1'b1);
        glitch(1, 1'b0);
        check_vals("glitch");

        // Duty cycle at 64, 0 and 255
        set_val(0, 8'd64);
        set_val(1, 8'd0);
        set_val(2, 8'd255);
        check_vals("pwm_set");
        for (int ch = 0; ch < 3; ch++) pwm_chk(ch);

        // Random walk with interleaved glitches
        for (int i = 0; i < 40; i++) begin
            move($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0)
                glitch($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        check_vals("walk");

        // Random levels and their duty cycles
        for (int r = 0; r < 2; r++) begin
            for (int ch = 0; ch < 3; ch++) set_val(ch, 8'($urandom_range(0, 255)));
            check_vals("rand_set");
            for (int ch = 0; ch < 3; ch++) pwm_chk(ch);
        end

        // Simultaneous A edges on all three channels
        for (int ch = 0; ch < 3; ch++) begin
            if (pa[ch] != pb[ch]) move(ch, 1'b1);
        end
        for (int ch = 0; ch < 3; ch++) begin
            pa[ch] = ~pa[ch];
            ev[ch] = (pa[ch] != pb[ch]) ? ev[ch] + 8'd1 : ev[ch] - 8'd1;
        end
        drive();
        tick(10);
        check_vals("simul");

        // Reset while pins are toggling
        for (int ch = 0; ch < 3; ch++) set_val(ch, 8'd100 + 8'(ch));
        pa = ~pa;
        drive();
        tick(4);
        rst_n = 1'b0;
        tick(1);
        ev[0] = 8'd0; ev[1] = 8'd0; ev[2] = 8'd0;
        chk("midrst_uo", int'(uo_out), 0);
        check_vals("midrst");
        pa = 3'b000;
        pb = 3'b000;
        drive();
        tick(10);
        rst_n = 1'b1;
        tick(12);
        check_vals("after_midrst");
        move(2, 1'b1);
        check_vals("resume");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
